// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmit framer and the future receiver.
//   uart_tx_state_t : transmit framer FSM states
//   PAR_*           : parity mode encodings for the PARITY parameter
//   parity_bit()    : parity of a (zero-extended) data word for a given mode
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Zero-extension of narrower words does not change the XOR reduction,
    // so one 9-bit helper covers every legal DATA_BITS.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        if (mode == PAR_ODD) begin
            return ~^data;
        end
        return ^data;
    endfunction

endpackage

// File: rtl/baud_edge_detect.sv
// ----------------------------------------------------------------------------
// baud_edge_detect
// Rising-edge detector for a baud level toggled in the clk domain.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset
//   level    in  : baud level (already synchronous to clk)
//   tick     out : high for the one cycle in which level is 1 and was 0
// RESET_VAL sets the delay flop's reset value; with 1 a level that is already
// high when reset releases is not reported as an edge.
// ----------------------------------------------------------------------------
module baud_edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic tick
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level;
        end
    end

    assign tick = level & ~level_q;

endmodule

// File: rtl/uart_tx_framer.sv
// ----------------------------------------------------------------------------
// uart_tx_framer
// Serial UART transmitter: start bit, LSB-first data, optional parity, and
// one or two stop bits, advanced on rising edges of the baud level.
//   clk        in  : system clock
//   rst_n      in  : asynchronous active-low reset
//   baud_clk   in  : transmit baud level, rising edge = bit boundary
//   tx_data    in  : word to send, sampled on handshake
//   tx_valid   in  : tx_data valid
//   tx_ready   out : word can be accepted (FSM idle)
//   tx         out : serial line, idles high
//   busy       out : frame pending or on the line
//   frame_done out : one-cycle pulse when the final stop bit ends
//
// state  | meaning
// IDLE   | line high, accepting a word
// ARMED  | word latched, waiting for the next bit boundary
// START  | driving the start bit
// DATA   | driving data bits, LSB first
// PARITY | driving the parity bit
// STOP   | driving stop bits
// ----------------------------------------------------------------------------
module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int                CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    uart_tx_state_t         state_q, state_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic                   parity_q, parity_d;
    logic                   tx_q, tx_d;
    logic                   frame_done_q, frame_done_d;
    logic                   tick;

    baud_edge_detect #(
        .RESET_VAL (1'b1)
    ) u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (baud_clk),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            stop_cnt_q   <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                // A tick in the acceptance cycle is deliberately not looked
                // at here; the start bit waits for the next boundary.
                if (tx_valid) begin
                    shift_d  = tx_data;
                    parity_d = parity_bit(9'(tx_data), PARITY);
                    state_d  = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    tx_d    = 1'b0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            tx_d    = parity_q;
                            state_d = ST_PARITY;
                        end else begin
                            tx_d       = 1'b1;
                            stop_cnt_d = 1'b0;
                            state_d    = ST_STOP;
                        end
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tx         = tx_q;
    assign tx_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule
